// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - two-requester round-robin scheduler for the shared 8-bit ALU

module alu_arbiter #(
   parameter int ALU_LAT = 1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       req0_valid,
   output logic       req0_ready,
   input  logic [3:0] req0_sel,
   input  logic [7:0] req0_a,
   input  logic [7:0] req0_b,
   input  logic       req1_valid,
   output logic       req1_ready,
   input  logic [3:0] req1_sel,
   input  logic [7:0] req1_a,
   input  logic [7:0] req1_b,
   output logic       resp0_valid,
   output logic       resp1_valid,
   output logic [7:0] resp_data,
   output logic [3:0] alu_sel,
   output logic [7:0] alu_a,
   output logic [7:0] alu_b,
   input  logic [7:0] alu_x,
   output logic       busy,
   output logic [7:0] op_count
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_EXEC = 2'd1;
   localparam logic [1:0] S_RESP = 2'd2;

   // Settle counter preload: EXEC lasts exactly ALU_LAT cycles, ending when cnt hits 0.
   localparam logic [3:0] LAT_M1 = 4'(ALU_LAT - 1);

   logic [1:0] state;
   logic       last_grant;  // requester granted most recently; the other wins a tie
   logic       owner;       // requester whose operation is in flight
   logic [3:0] cnt;
   logic       idle;

   // Handshake, response strobes and busy decode straight from the state register.
   always_comb begin
      idle        = (state == S_IDLE);
      req0_ready  = idle & req0_valid & (~req1_valid | last_grant);
      req1_ready  = idle & req1_valid & (~req0_valid | ~last_grant);
      resp0_valid = (state == S_RESP) & ~owner;
      resp1_valid = (state == S_RESP) & owner;
      busy        = ~idle;
   end

   // Control FSM plus operand/result registers; operands and result persist until overwritten.
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= S_IDLE;
         last_grant <= 1'b1;
         owner      <= 1'b0;
         cnt        <= 4'd0;
         alu_sel    <= 4'd0;
         alu_a      <= 8'd0;
         alu_b      <= 8'd0;
         resp_data  <= 8'd0;
         op_count   <= 8'd0;
      end else begin
         case (state)
            S_IDLE: begin
               if (req0_ready) begin
                  alu_sel    <= req0_sel;
                  alu_a      <= req0_a;
                  alu_b      <= req0_b;
                  owner      <= 1'b0;
                  last_grant <= 1'b0;
                  cnt        <= LAT_M1;
                  state      <= S_EXEC;
               end else if (req1_ready) begin
                  alu_sel    <= req1_sel;
                  alu_a      <= req1_a;
                  alu_b      <= req1_b;
                  owner      <= 1'b1;
                  last_grant <= 1'b1;
                  cnt        <= LAT_M1;
                  state      <= S_EXEC;
               end
            end
            S_EXEC: begin
               if (cnt == 4'd0) begin
                  resp_data <= alu_x;
                  op_count  <= op_count + 8'd1;
                  state     <= S_RESP;
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
            S_RESP: begin
               state <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - directed self-checking bench for alu_arbiter

module tb_alu_arbiter;

   logic       clk = 1'b0;
   logic       reset = 1'b1;

   logic       req0_valid = 1'b0, req1_valid = 1'b0;
   logic [3:0] req0_sel = 4'd0, req1_sel = 4'd0;
   logic [7:0] req0_a = 8'd0, req0_b = 8'd0, req1_a = 8'd0, req1_b = 8'd0;
   logic       req0_ready, req1_ready, resp0_valid, resp1_valid, busy;
   logic [7:0] resp_data, alu_a, alu_b, alu_x, op_count;
   logic [3:0] alu_sel;

   logic       l4_req0_valid = 1'b0, l4_req1_valid = 1'b0;
   logic [3:0] l4_req0_sel = 4'd0, l4_req1_sel = 4'd0;
   logic [7:0] l4_req0_a = 8'd0, l4_req0_b = 8'd0, l4_req1_a = 8'd0, l4_req1_b = 8'd0;
   logic       l4_req0_ready, l4_req1_ready, l4_resp0_valid, l4_resp1_valid, l4_busy;
   logic [7:0] l4_resp_data, l4_alu_a, l4_alu_b, l4_alu_x, l4_op_count;
   logic [3:0] l4_alu_sel;

   int n_checks = 0;
   int n_pass = 0;

   assign alu_x    = alu_a ^ alu_b;
   assign l4_alu_x = l4_alu_a ^ l4_alu_b;

   always #5 clk = ~clk;

   alu_arbiter #(.ALU_LAT(1)) u1 (
      .clk(clk), .reset(reset),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_sel(req0_sel), .req0_a(req0_a), .req0_b(req0_b),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_sel(req1_sel), .req1_a(req1_a), .req1_b(req1_b),
      .resp0_valid(resp0_valid), .resp1_valid(resp1_valid), .resp_data(resp_data),
      .alu_sel(alu_sel), .alu_a(alu_a), .alu_b(alu_b), .alu_x(alu_x),
      .busy(busy), .op_count(op_count)
   );

   alu_arbiter #(.ALU_LAT(4)) u4 (
      .clk(clk), .reset(reset),
      .req0_valid(l4_req0_valid), .req0_ready(l4_req0_ready), .req0_sel(l4_req0_sel), .req0_a(l4_req0_a), .req0_b(l4_req0_b),
      .req1_valid(l4_req1_valid), .req1_ready(l4_req1_ready), .req1_sel(l4_req1_sel), .req1_a(l4_req1_a), .req1_b(l4_req1_b),
      .resp0_valid(l4_resp0_valid), .resp1_valid(l4_resp1_valid), .resp_data(l4_resp_data),
      .alu_sel(l4_alu_sel), .alu_a(l4_alu_a), .alu_b(l4_alu_b), .alu_x(l4_alu_x),
      .busy(l4_busy), .op_count(l4_op_count)
   );

   // Advance to 1 ns after the next rising edge: inputs change here, checks follow after #1.
   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      next_cycle();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      next_cycle();
      next_cycle();
      reset = 1'b0;
      #1;
      n_checks++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b expected 0", busy); else n_pass++;
      n_checks++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) $display("FAIL rst_ready: got %b%b expected 00", req0_ready, req1_ready); else n_pass++;
      n_checks++; if (resp0_valid !== 1'b0 || resp1_valid !== 1'b0) $display("FAIL rst_resp: got %b%b expected 00", resp0_valid, resp1_valid); else n_pass++;
      n_checks++; if ({alu_sel, alu_a, alu_b} !== 20'h0) $display("FAIL rst_alu: got %h expected 0", {alu_sel, alu_a, alu_b}); else n_pass++;
      n_checks++; if (resp_data !== 8'h00 || op_count !== 8'h00) $display("FAIL rst_data_cnt: got %h/%h expected 00/00", resp_data, op_count); else n_pass++;
      n_checks++; if (l4_busy !== 1'b0 || l4_op_count !== 8'h00) $display("FAIL rst_l4: got %b/%h expected 0/00", l4_busy, l4_op_count); else n_pass++;
   endtask

   task automatic test_single();
      do_reset();
      req0_valid = 1'b1; req0_sel = 4'b0001; req0_a = 8'h01; req0_b = 8'h04;
      #1;
      n_checks++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) $display("FAIL single_ready: got %b%b expected 10", req0_ready, req1_ready); else n_pass++;
      next_cycle();
      req0_valid = 1'b0;
      #1;
      n_checks++; if (alu_a !== 8'h01 || alu_b !== 8'h04 || alu_sel !== 4'h1) $display("FAIL single_alu_in: got %h/%h/%h expected 01/04/1", alu_a, alu_b, alu_sel); else n_pass++;
      n_checks++; if (busy !== 1'b1 || resp0_valid !== 1'b0) $display("FAIL single_exec: got busy=%b resp0=%b expected 1/0", busy, resp0_valid); else n_pass++;
      next_cycle();
      #1;
      n_checks++; if (resp0_valid !== 1'b1 || resp1_valid !== 1'b0) $display("FAIL single_resp: got %b%b expected 10", resp0_valid, resp1_valid); else n_pass++;
      n_checks++; if (resp_data !== 8'h05 || op_count !== 8'd1) $display("FAIL single_data: got %h/%0d expected 05/1", resp_data, op_count); else n_pass++;
      next_cycle();
      #1;
      n_checks++; if (resp0_valid !== 1'b0 || busy !== 1'b0) $display("FAIL single_done: got resp0=%b busy=%b expected 0/0", resp0_valid, busy); else n_pass++;
   endtask

   task automatic test_contention();
      do_reset();
      req0_valid = 1'b1; req0_sel = 4'h2; req0_a = 8'hFF; req0_b = 8'h81;
      req1_valid = 1'b1; req1_sel = 4'h4; req1_a = 8'h7F; req1_b = 8'h41;
      #1;
      n_checks++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) $display("FAIL cont_tie1: got %b%b expected 10", req0_ready, req1_ready); else n_pass++;
      next_cycle();
      req0_valid = 1'b0;
      #1;
      n_checks++; if (req1_ready !== 1'b0) $display("FAIL cont_exec_ready: got %b expected 0", req1_ready); else n_pass++;
      next_cycle();
      #1;
      n_checks++; if (resp0_valid !== 1'b1 || resp_data !== 8'h7E || req1_ready !== 1'b0) $display("FAIL cont_resp0: got %b/%h/%b expected 1/7e/0", resp0_valid, resp_data, req1_ready); else n_pass++;
      next_cycle();
      req0_valid = 1'b1; req0_a = 8'h12; req0_b = 8'h34;
      #1;
      n_checks++; if (req0_ready !== 1'b0 || req1_ready !== 1'b1) $display("FAIL cont_tie2: got %b%b expected 01", req0_ready, req1_ready); else n_pass++;
      next_cycle();
      req1_valid = 1'b0;
      #1;
      n_checks++; if (alu_a !== 8'h7F || alu_sel !== 4'h4) $display("FAIL cont_alu1: got %h/%h expected 7f/4", alu_a, alu_sel); else n_pass++;
      next_cycle();
      #1;
      n_checks++; if (resp1_valid !== 1'b1 || resp0_valid !== 1'b0 || resp_data !== 8'h3E) $display("FAIL cont_resp1: got %b%b/%h expected 01/3e", resp0_valid, resp1_valid, resp_data); else n_pass++;
      next_cycle();
      req1_valid = 1'b1;
      #1;
      n_checks++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) $display("FAIL cont_tie3: got %b%b expected 10", req0_ready, req1_ready); else n_pass++;
      next_cycle();
      req0_valid = 1'b0;
      next_cycle();
      #1;
      n_checks++; if (resp0_valid !== 1'b1 || resp_data !== 8'h26) $display("FAIL cont_resp2: got %b/%h expected 1/26", resp0_valid, resp_data); else n_pass++;
      next_cycle();
      #1;
      n_checks++; if (req1_ready !== 1'b1) $display("FAIL cont_tie4: got %b expected 1", req1_ready); else n_pass++;
      next_cycle();
      req1_valid = 1'b0;
      next_cycle();
      next_cycle();
   endtask

   task automatic test_latency();
      do_reset();
      l4_req1_valid = 1'b1; l4_req1_sel = 4'h3; l4_req1_a = 8'h85; l4_req1_b = 8'h05;
      #1;
      n_checks++; if (l4_req1_ready !== 1'b1) $display("FAIL lat_ready: got %b expected 1", l4_req1_ready); else n_pass++;
      for (int k = 1; k <= 4; k++) begin
         next_cycle();
         if (k == 1) l4_req1_valid = 1'b0;
         if (k == 2) begin
            l4_req0_valid = 1'b1; l4_req0_sel = 4'hC; l4_req0_a = 8'hAA; l4_req0_b = 8'h55;
         end
         #1;
         n_checks++; if ({l4_alu_sel, l4_alu_a, l4_alu_b} !== 20'h38505) $display("FAIL lat_hold_%0d: got %h expected 38505", k, {l4_alu_sel, l4_alu_a, l4_alu_b}); else n_pass++;
         n_checks++; if (l4_busy !== 1'b1 || l4_resp1_valid !== 1'b0 || l4_req0_ready !== 1'b0) $display("FAIL lat_exec_%0d: got busy=%b resp1=%b rdy0=%b expected 1/0/0", k, l4_busy, l4_resp1_valid, l4_req0_ready); else n_pass++;
      end
      next_cycle();
      #1;
      n_checks++; if (l4_resp1_valid !== 1'b1 || l4_resp0_valid !== 1'b0 || l4_resp_data !== 8'h80 || l4_busy !== 1'b1) $display("FAIL lat_resp: got %b%b/%h/%b expected 01/80/1", l4_resp0_valid, l4_resp1_valid, l4_resp_data, l4_busy); else n_pass++;
      next_cycle();
      #1;
      n_checks++; if (l4_busy !== 1'b0 || l4_resp1_valid !== 1'b0 || l4_req0_ready !== 1'b1) $display("FAIL lat_idle: got busy=%b resp1=%b rdy0=%b expected 0/0/1", l4_busy, l4_resp1_valid, l4_req0_ready); else n_pass++;
      next_cycle();
      l4_req0_valid = 1'b0;
   endtask

   task automatic test_back_to_back();
      int accepts = 0;
      int last = 0;
      int gap_bad = 0;
      int viol = 0;
      do_reset();
      req0_sel = 4'h6; req0_a = 8'h10; req0_b = 8'h03;
      for (int c = 0; c < 30 && accepts < 3; c++) begin
         if (c > 0) next_cycle();
         req0_valid = 1'b1;
         #1;
         if (req0_ready && busy) viol++;
         if (req0_ready) begin
            if (accepts > 0 && (c - last) != 3) gap_bad++;
            last = c;
            accepts++;
         end
      end
      next_cycle();
      req0_valid = 1'b0;
      #1;
      if (req0_ready && busy) viol++;
      n_checks++; if (accepts !== 3) $display("FAIL b2b_accepts: got %0d expected 3", accepts); else n_pass++;
      n_checks++; if (gap_bad !== 0) $display("FAIL b2b_spacing: got %0d bad gaps expected 0", gap_bad); else n_pass++;
      n_checks++; if (viol !== 0) $display("FAIL b2b_ready_busy: got %0d overlaps expected 0", viol); else n_pass++;
      next_cycle();
      #1;
      n_checks++; if (resp0_valid !== 1'b1 || resp_data !== 8'h13 || op_count !== 8'd3) $display("FAIL b2b_final: got %b/%h/%0d expected 1/13/3", resp0_valid, resp_data, op_count); else n_pass++;
      next_cycle();
   endtask

   task automatic test_reset_midop();
      do_reset();
      req0_valid = 1'b1; req0_sel = 4'h9; req0_a = 8'h33; req0_b = 8'h0F;
      #1;
      n_checks++; if (req0_ready !== 1'b1) $display("FAIL midop_accept: got %b expected 1", req0_ready); else n_pass++;
      next_cycle();
      req0_valid = 1'b0;
      reset = 1'b1;
      #1;
      n_checks++; if (busy !== 1'b1) $display("FAIL midop_exec: got %b expected 1", busy); else n_pass++;
      next_cycle();
      reset = 1'b0;
      req0_valid = 1'b1; req0_sel = 4'h1; req0_a = 8'h0C; req0_b = 8'h30;
      req1_valid = 1'b1; req1_sel = 4'h2; req1_a = 8'h11; req1_b = 8'h22;
      #1;
      n_checks++; if (resp0_valid !== 1'b0 || resp1_valid !== 1'b0 || busy !== 1'b0) $display("FAIL midop_nopulse: got %b%b busy=%b expected 00/0", resp0_valid, resp1_valid, busy); else n_pass++;
      n_checks++; if ({alu_sel, alu_a, alu_b, resp_data, op_count} !== 36'h0) $display("FAIL midop_cleared: got %h expected 0", {alu_sel, alu_a, alu_b, resp_data, op_count}); else n_pass++;
      n_checks++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) $display("FAIL midop_tie: got %b%b expected 10", req0_ready, req1_ready); else n_pass++;
      next_cycle();
      req0_valid = 1'b0; req1_valid = 1'b0;
      next_cycle();
      #1;
      n_checks++; if (resp0_valid !== 1'b1 || resp1_valid !== 1'b0 || resp_data !== 8'h3C) $display("FAIL midop_after: got %b%b/%h expected 10/3c", resp0_valid, resp1_valid, resp_data); else n_pass++;
      next_cycle();
   endtask

   task automatic test_wrap();
      int timeouts = 0;
      int bad = 0;
      logic got;
      logic [7:0] exp;
      logic [7:0] cnt_254 = 8'h00;
      logic [7:0] last_data = 8'h00;
      do_reset();
      for (int i = 0; i < 256; i++) begin
         req0_sel = 4'(i); req0_a = 8'(i); req0_b = 8'h5A;
         req0_valid = 1'b1;
         exp = 8'(i) ^ 8'h5A;
         got = 1'b0;
         for (int w = 0; w < 8; w++) begin
            if (w > 0) next_cycle();
            #1;
            if (req0_ready) begin
               got = 1'b1;
               break;
            end
         end
         if (!got) timeouts++;
         next_cycle();
         req0_valid = 1'b0;
         next_cycle();
         #1;
         if (resp0_valid !== 1'b1 || resp_data !== exp) bad++;
         if (i == 254) cnt_254 = op_count;
         last_data = resp_data;
         next_cycle();
      end
      n_checks++; if (timeouts !== 0) $display("FAIL wrap_timeout: got %0d stalled ops expected 0", timeouts); else n_pass++;
      n_checks++; if (bad !== 0) $display("FAIL wrap_data: got %0d bad responses expected 0", bad); else n_pass++;
      n_checks++; if (cnt_254 !== 8'd255) $display("FAIL wrap_cnt255: got %0d expected 255", cnt_254); else n_pass++;
      n_checks++; if (op_count !== 8'd0) $display("FAIL wrap_cnt0: got %0d expected 0", op_count); else n_pass++;
      n_checks++; if (last_data !== 8'hA5) $display("FAIL wrap_last_data: got %h expected a5", last_data); else n_pass++;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_single();
      test_contention();
      test_latency();
      test_back_to_back();
      test_reset_midop();
      test_wrap();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
